// File: rtl/alu_iter.sv
// alu_iter: handshaked, registered ALU with iterative unsigned multiply/divide.
//
// Single-cycle ops register their result at the accept edge. MUL/MULHU/DIVU/REMU
// (and signed DIV when ALU_ITER_SIGNED_DIV_EN is defined) iterate one bit per
// cycle for XLEN cycles. Without ALU_ITER_SIGNED_DIV_EN, op 4'b1111 is a
// reserved single-cycle op that returns 0.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   req_val   request valid
//   req_rdy   block can accept a request (IDLE only)
//   op        operation code
//   srca      operand A
//   srcb      operand B (shift amount is srcb[SHW-1:0])
//   resp_val  result valid (DONE only)
//   resp_rdy  consumer accepts result
//   result    registered result
//   cnd       {result[XLEN-1], result == 0}, registered with result
module alu_iter #(
  parameter int unsigned  XLEN = 32,
  localparam int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_val,
  output logic            req_rdy,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            resp_val,
  input  logic            resp_rdy,
  output logic [XLEN-1:0] result,
  output logic [1:0]      cnd
);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSlt   = 4'b0001;
  localparam logic [3:0] OpSltu  = 4'b0010;
  localparam logic [3:0] OpAnd   = 4'b0011;
  localparam logic [3:0] OpOr    = 4'b0100;
  localparam logic [3:0] OpXor   = 4'b0101;
  localparam logic [3:0] OpSll   = 4'b0110;
  localparam logic [3:0] OpSrl   = 4'b0111;
  localparam logic [3:0] OpSub   = 4'b1000;
  localparam logic [3:0] OpSra   = 4'b1001;
  localparam logic [3:0] OpAm    = 4'b1010;
  localparam logic [3:0] OpMul   = 4'b1011;
  localparam logic [3:0] OpMulhu = 4'b1100;
  localparam logic [3:0] OpDivu  = 4'b1101;
  localparam logic [3:0] OpRemu  = 4'b1110;
`ifdef ALU_ITER_SIGNED_DIV_EN
  localparam logic [3:0] OpDiv   = 4'b1111;
`endif

  localparam logic [SHW-1:0] CntLast = SHW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;       // multiplier (shifts right) / dividend->quotient (shifts left)
  logic [XLEN-1:0]     b_q, b_d;       // multiplicand / divisor
  logic [2*XLEN-1:0]   acc_q, acc_d;   // product accumulator; low half doubles as the remainder
  logic [XLEN-1:0]     result_q, result_d;
  logic [1:0]          cnd_q, cnd_d;
`ifdef ALU_ITER_SIGNED_DIV_EN
  logic                neg_q, neg_d;   // negate quotient at the end
`endif

  function automatic logic [1:0] cond_of(input logic [XLEN-1:0] r);
    return {r[XLEN-1], r == '0};
  endfunction

  // Single-cycle datapath
  logic [XLEN-1:0] sum, diff, alu_res;
  logic [SHW-1:0]  shamt;
  logic            is_iter;

  assign sum   = srca + srcb;
  assign diff  = srca - srcb;
  assign shamt = srcb[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = sum;
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, srca < srcb};
      OpAnd:   alu_res = srca & srcb;
      OpOr:    alu_res = srca | srcb;
      OpXor:   alu_res = srca ^ srcb;
      OpSll:   alu_res = srca << shamt;
      OpSrl:   alu_res = srca >> shamt;
      OpSub:   alu_res = diff;
      OpSra:   alu_res = $unsigned($signed(srca) >>> shamt);
      OpAm:    alu_res = {sum[XLEN-1:1], 1'b0};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_ITER_SIGNED_DIV_EN
  assign is_iter = op inside {OpMul, OpMulhu, OpDivu, OpRemu, OpDiv};
`else
  assign is_iter = op inside {OpMul, OpMulhu, OpDivu, OpRemu};
`endif

  // Iterative step datapath
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem, div_quo, iter_res;
  logic              is_mul_q;

  // Shift-add: add multiplicand into the high half, then shift the whole accumulator right.
  assign mul_addend = a_q[0] ? b_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
  assign mul_acc    = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring division: remainder < divisor, so the difference fits in XLEN bits.
  // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
  assign div_shift = {acc_q[XLEN-1:0], a_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_rem   = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
  assign div_quo   = {a_q[XLEN-2:0], div_ge};

  assign is_mul_q = (op_q == OpMul) || (op_q == OpMulhu);

  always_comb begin
    iter_res = '0;
    case (op_q)
      OpMul:   iter_res = mul_acc[XLEN-1:0];
      OpMulhu: iter_res = mul_acc[2*XLEN-1:XLEN];
      OpDivu:  iter_res = div_quo;
      OpRemu:  iter_res = div_rem;
`ifdef ALU_ITER_SIGNED_DIV_EN
      OpDiv:   iter_res = neg_q ? -div_quo : div_quo;
`endif
      default: iter_res = '0;
    endcase
  end

  // Next-state and outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnd_d    = cnd_q;
`ifdef ALU_ITER_SIGNED_DIV_EN
    neg_d    = neg_q;
`endif
    req_rdy  = 1'b0;
    resp_val = 1'b0;

    case (state_q)
      StIdle: begin
        req_rdy = 1'b1;
        if (req_val) begin
          if (is_iter) begin
            op_d    = op;
            a_d     = srca;
            b_d     = srcb;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StBusy;
`ifdef ALU_ITER_SIGNED_DIV_EN
            neg_d   = 1'b0;
            if (op == OpDiv) begin
              a_d   = srca[XLEN-1] ? -srca : srca;
              b_d   = srcb[XLEN-1] ? -srcb : srcb;
              // Zero divisor must stay all ones, so no sign fixup then.
              neg_d = (srca[XLEN-1] ^ srcb[XLEN-1]) && (srcb != '0);
            end
`endif
          end else begin
            result_d = alu_res;
            cnd_d    = cond_of(alu_res);
            state_d  = StDone;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + SHW'(1);
        if (is_mul_q) begin
          acc_d = mul_acc;
          a_d   = {1'b0, a_q[XLEN-1:1]};
        end else begin
          acc_d = {acc_q[2*XLEN-1:XLEN], div_rem};
          a_d   = div_quo;
        end
        if (cnt_q == CntLast) begin
          result_d = iter_res;
          cnd_d    = cond_of(iter_res);
          state_d  = StDone;
        end
      end
      StDone: begin
        resp_val = 1'b1;
        if (resp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnd_q    <= 2'b01;
`ifdef ALU_ITER_SIGNED_DIV_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnd_q    <= cnd_d;
`ifdef ALU_ITER_SIGNED_DIV_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign result = result_q;
  assign cnd    = cnd_q;

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_val;
  logic            req_rdy;
  logic [3:0]      op;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            resp_val;
  logic            resp_rdy;
  logic [XLEN-1:0] result;
  logic [1:0]      cnd;

  int n_vec = 0;
  int n_err = 0;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .op       (op),
    .srca     (srca),
    .srcb     (srcb),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .result   (result),
    .cnd      (cnd)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: plain arithmetic on 64-bit products and native division.
  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd2:  r = (a < b) ? 32'd1 : 32'd0;
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = a << b[4:0];
      4'd7:  r = a >> b[4:0];
      4'd8:  r = a - b;
      4'd9:  r = $signed(a) >>> b[4:0];
      4'd10: r = (a + b) & 32'hFFFF_FFFE;
      4'd11: r = p[31:0];
      4'd12: r = p[63:32];
      4'd13: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: r = (b == 0) ? a : a % b;
      default: begin
`ifdef ALU_ITER_SIGNED_DIV_EN
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
`else
        r = 32'd0;
`endif
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] o);
`ifdef ALU_ITER_SIGNED_DIV_EN
    return (o >= 4'd11) ? 33 : 1;
`else
    return (o >= 4'd11 && o <= 4'd14) ? 33 : 1;
`endif
  endfunction

  // Issue one request from an idle DUT and wait (bounded) for resp_val.
  // Returns with the DUT in DONE and resp_rdy low.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [1:0] c, output int lat);
    op = o; srca = a; srcb = b; req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    op = 4'($urandom); srca = $urandom; srcb = $urandom;
    lat = 1;
    while (!resp_val && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; c = cnd;
  endtask

  task automatic retire();
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_val = 1'b0; resp_rdy = 1'b0; op = '0; srca = '0; srcb = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL reset_req_rdy: got %b want 1", req_rdy); end
      n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL reset_resp_val: got %b want 0", resp_val); end
      n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
      n_vec++; if (cnd !== 2'b01) begin n_err++; $display("FAIL reset_cnd: got %b want 01", cnd); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_directed();
    logic [3:0]  d_op  [11] = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd9, 4'd11, 4'd12, 4'd13, 4'd14,
                                4'd13, 4'd14};
    logic [31:0] d_a   [11] = '{32'hA, 32'hFFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h1234,
                                32'h1234};
    logic [31:0] d_b   [11] = '{32'h1, 32'hFFFA, 32'h1, 32'h1, 32'h24, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd7, 32'd7, 32'h0, 32'h0};
    logic [31:0] d_exp [11] = '{32'hB, 32'h0, 32'h1, 32'h0, 32'hF800_0000, 32'h1,
                                32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234};
    logic [31:0] r;
    logic [1:0]  c;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      issue(d_op[i], d_a[i], d_b[i], r, c, lat);
      n_vec++; if (r !== d_exp[i]) begin n_err++; $display("FAIL directed_result[%0d] op=%h: got %h want %h", i, d_op[i], r, d_exp[i]); end
      n_vec++; if (c !== {d_exp[i][31], d_exp[i] == 0}) begin n_err++; $display("FAIL directed_cnd[%0d]: got %b want %b", i, c, {d_exp[i][31], d_exp[i] == 0}); end
      n_vec++; if (lat !== ref_lat(d_op[i])) begin n_err++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, ref_lat(d_op[i])); end
      retire();
    end
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [31:0] a, b, r, e;
    logic [1:0]  c;
    int          lat;
    for (int i = 0; i < 48; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 6 == 1) b = 32'($urandom_range(0, 40));
      if (i % 11 == 4) b = '0;
      if (i % 9 == 2) a = b;
      issue(o, a, b, r, c, lat);
      e = ref_alu(o, a, b);
      n_vec++; if (r !== e) begin n_err++; $display("FAIL random_result op=%h a=%h b=%h: got %h want %h", o, a, b, r, e); end
      n_vec++; if (c !== {e[31], e == 0}) begin n_err++; $display("FAIL random_cnd op=%h: got %b want %b", o, c, {e[31], e == 0}); end
      n_vec++; if (lat !== ref_lat(o)) begin n_err++; $display("FAIL random_latency op=%h: got %0d want %0d", o, lat, ref_lat(o)); end
      retire();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, a, b;
    logic [1:0]  c;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      issue(4'd5, a, b, r, c, lat);
      n_vec++; if (r !== (a ^ b)) begin n_err++; $display("FAIL b2b_result: got %h want %h", r, a ^ b); end
      retire();
      n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL b2b_resp_val_drop: got %b want 0", resp_val); end
      n_vec++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_req_rdy: got %b want 1", req_rdy); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] r, a, b;
    logic [1:0]  c;
    int          lat;
    a = $urandom; b = $urandom;
    issue(4'd0, a, b, r, c, lat);
    for (int i = 0; i < 5; i++) begin
      req_val = ~req_val;
      op = 4'($urandom); srca = $urandom; srcb = $urandom;
      @(posedge clk); #1;
      n_vec++; if (result !== a + b) begin n_err++; $display("FAIL hold_result[%0d]: got %h want %h", i, result, a + b); end
      n_vec++; if (req_rdy !== 1'b0) begin n_err++; $display("FAIL hold_req_rdy[%0d]: got %b want 0", i, req_rdy); end
      n_vec++; if (resp_val !== 1'b1) begin n_err++; $display("FAIL hold_resp_val[%0d]: got %b want 1", i, resp_val); end
    end
    req_val = 1'b0;
    retire();
    n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL hold_release: got resp_val %b want 0", resp_val); end
  endtask

  task automatic test_rst_done();
    logic [31:0] r;
    logic [1:0]  c;
    int          lat;
    issue(4'd4, 32'h8000_00F0, 32'h0F, r, c, lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL rst_done_resp_val: got %b want 0", resp_val); end
    n_vec++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL rst_done_req_rdy: got %b want 1", req_rdy); end
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_done_result: got %h want 0", result); end
    n_vec++; if (cnd !== 2'b01) begin n_err++; $display("FAIL rst_done_cnd: got %b want 01", cnd); end
  endtask

  task automatic test_rst_busy();
    logic [31:0] r;
    logic [1:0]  c;
    int          lat;
    int          seen;
    op = 4'd13; srca = 32'd1000; srcb = 32'd3; req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_vec++; if (req_rdy !== 1'b0) begin n_err++; $display("FAIL rst_busy_pre_req_rdy: got %b want 0", req_rdy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL rst_busy_req_rdy: got %b want 1", req_rdy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_val !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rst_busy_resp_val: got %0d high cycles want 0", seen); end
    issue(4'd0, 32'h1234_5678, 32'h1111_1111, r, c, lat);
    n_vec++; if (r !== 32'h2345_6789) begin n_err++; $display("FAIL rst_busy_fresh_add: got %h want 23456789", r); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL rst_busy_fresh_latency: got %0d want 1", lat); end
    retire();
  endtask

`ifdef ALU_ITER_SIGNED_DIV_EN
  task automatic test_signed();
    logic [31:0] s_a   [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0064, 32'hFFFF_FF9C};
    logic [31:0] s_b   [4] = '{32'h2, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF9};
    logic [31:0] s_exp [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hE};
    logic [31:0] r, a, b, e;
    logic [1:0]  c;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      issue(4'd15, s_a[i], s_b[i], r, c, lat);
      n_vec++; if (r !== s_exp[i]) begin n_err++; $display("FAIL sdiv_result[%0d]: got %h want %h", i, r, s_exp[i]); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL sdiv_latency[%0d]: got %0d want 33", i, lat); end
      retire();
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom >> $urandom_range(0, 28);
      if (i % 2 == 1) b = -b;
      issue(4'd15, a, b, r, c, lat);
      e = ref_alu(4'd15, a, b);
      n_vec++; if (r !== e) begin n_err++; $display("FAIL sdiv_random a=%h b=%h: got %h want %h", a, b, r, e); end
      retire();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold();
    test_rst_done();
    test_rst_busy();
`ifdef ALU_ITER_SIGNED_DIV_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
